// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states, alignment rule.
// Pure declarations; no logic of its own.
package load_store_unit_pkg;

    localparam int LSU_ADDR_W = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response bus and data_mem-side word bus of the load/store unit.
// Request side is valid/ready; response is a single-cycle pulse with no ready.
interface lsu_req_if;
    import load_store_unit_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [LSU_ADDR_W-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    import load_store_unit_pkg::*;

    logic [LSU_ADDR_W-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit_lane.sv
// Big-endian lane extract (with zero/sign extension) and lane merge for sub-word stores.
// Purely combinational, zero latency, no flow control.
module lsu_lane
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_ext,
    output logic [31:0] o_merge
);

    // Offset 0 is the most significant byte, so the shift is (3 - off) * 8.
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = {~i_off, 3'b000};

    always_comb begin
        w_byte  = 8'(i_word >> w_shift);
        w_half  = i_off[1] ? i_word[15:0] : i_word[31:16];
        o_ext   = i_word;
        o_merge = i_new;
        case (i_size)
            SZ_BYTE: begin
                o_ext   = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge = (i_old & ~(32'h0000_00FF << w_shift)) |
                          ({24'h0, i_new[7:0]} << w_shift);
            end
            SZ_HALF: begin
                o_ext   = {{16{i_signed & w_half[15]}}, w_half};
                o_merge = i_off[1] ? {i_old[31:16], i_new[15:0]}
                                   : {i_new[15:0], i_old[15:0]};
            end
            default: begin
                o_ext   = i_word;
                o_merge = i_new;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word loads and stores into word accesses on data_mem (RMW for sub-word stores).
// Latency: error 1, load/word store 2, sub-word store 3 cycles; req_ready only in IDLE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input logic       i_clk,
    input logic       i_rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    lsu_state_e r_state;
    lsu_state_e w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic [31:0]       r_old_word;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic        w_accept;
    logic        w_misal;
    logic [31:0] w_ext;
    logic [31:0] w_merge;

    assign w_accept = req.req_valid && (r_state == ST_IDLE);
    assign w_misal  = is_misaligned(req.req_size, req.req_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misal)
                        w_next = ST_RESP;
                    else if (req.req_we && (req.req_size == SZ_WORD))
                        w_next = ST_WR;
                    else
                        w_next = ST_RD;
                end
            end
            ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_wdata    <= '0;
            r_old_word <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req.req_addr;
                r_size   <= req.req_size;
                r_we     <= req.req_we;
                r_signed <= req.req_signed;
                r_wdata  <= req.req_wdata;
                r_rdata  <= '0;
                r_err    <= w_misal;
            end
            // The RD cycle serves both loads and the read half of an RMW.
            if (r_state == ST_RD) begin
                r_old_word <= mem.mem_rdata;
                if (!r_we) r_rdata <= w_ext;
            end
        end
    end

    lsu_lane u_lane (
        .i_word   (mem.mem_rdata),
        .i_old    (r_old_word),
        .i_new    (r_wdata),
        .i_off    (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_ext    (w_ext),
        .o_merge  (w_merge)
    );

    assign req.req_ready  = (r_state == ST_IDLE);
    assign req.resp_valid = (r_state == ST_RESP);
    assign req.resp_rdata = (r_state == ST_RESP) ? r_rdata : 32'h0;
    assign req.resp_err   = (r_state == ST_RESP) ? r_err : 1'b0;

    // Reset gates the write so an RMW interrupted in WR never lands in memory.
    assign mem.mem_rd    = (r_state == ST_RD);
    assign mem.mem_wr    = (r_state == ST_WR) && !i_rst;
    assign mem.mem_addr  = ((r_state == ST_RD) || (r_state == ST_WR)) ?
                           {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem.mem_wdata = (r_state == ST_WR) ? w_merge : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data_mem model plus a byte-level reference memory.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if u_req ();
    lsu_mem_if u_mem ();

    load_store_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .req   (u_req),
        .mem   (u_mem)
    );

    logic [7:0] mem_bytes [32] = '{default: 8'h00};
    logic [7:0] ref_mem   [32] = '{default: 8'h00};
    logic [4:0] wa;

    assign u_mem.mem_rdata = {mem_bytes[u_mem.mem_addr],        mem_bytes[u_mem.mem_addr + 5'd1],
                              mem_bytes[u_mem.mem_addr + 5'd2], mem_bytes[u_mem.mem_addr + 5'd3]};

    always @(negedge clk) begin
        if (u_mem.mem_wr) begin
            wa = u_mem.mem_addr;
            mem_bytes[wa]        <= u_mem.mem_wdata[31:24];
            mem_bytes[wa + 5'd1] <= u_mem.mem_wdata[23:16];
            mem_bytes[wa + 5'd2] <= u_mem.mem_wdata[15:8];
            mem_bytes[wa + 5'd3] <= u_mem.mem_wdata[7:0];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference: a request is a run of 1/2/4 bytes starting at addr, MSB first.
    task automatic ref_apply(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [4:0] addr, input logic [31:0] wdata,
                             output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                             output logic e_rd, output logic e_wr);
        int nb;
        logic [31:0] v;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        e_err = (size == 2'b11) || (int'(addr) % nb != 0);
        e_rdata = 32'h0;
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (e_err) begin
            e_lat = 1;
        end else if (we) begin
            for (int i = 0; i < nb; i++)
                ref_mem[int'(addr) + i] = wdata[8*(nb-1-i) +: 8];
            e_lat = (nb == 4) ? 2 : 3;
            e_rd = (nb != 4);
            e_wr = 1'b1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++)
                v = (v << 8) | {24'h0, ref_mem[int'(addr) + i]};
            if (sgn && nb < 4 && v[8*nb-1])
                v = v | (32'hFFFF_FFFF << (8*nb));
            e_rdata = v;
            e_lat = 2;
            e_rd = 1'b1;
        end
    endtask

    // Drives one request, waits for its response (bounded) and reports what was seen.
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [4:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic saw_rd, output logic saw_wr, output logic rdy_ok,
                         output logic done);
        logic acc;
        int n;
        u_req.req_valid  = 1'b1;
        u_req.req_we     = we;
        u_req.req_size   = size;
        u_req.req_signed = sgn;
        u_req.req_addr   = addr;
        u_req.req_wdata  = wdata;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = u_req.req_ready;
            @(posedge clk);
            n++;
        end
        #1 u_req.req_valid = 1'b0;
        lat = 1;
        done = 1'b0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        rdy_ok = acc;
        rdata = 32'h0;
        err = 1'b0;
        while (acc && !done && lat <= 8) begin
            @(negedge clk);
            if (u_req.req_ready) rdy_ok = 1'b0;
            if (u_mem.mem_rd) saw_rd = 1'b1;
            if (u_mem.mem_wr) saw_wr = 1'b1;
            if (u_req.resp_valid) begin
                done = 1'b1;
                rdata = u_req.resp_rdata;
                err = u_req.resp_err;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({u_req.resp_valid, u_req.resp_rdata, u_req.resp_err, u_mem.mem_rd, u_mem.mem_wr,
             u_mem.mem_addr, u_mem.mem_wdata} !== 72'h0) begin
            failures++;
            $display("FAIL reset_outputs got rv=%0b rd=%h er=%0b mrd=%0b mwr=%0b ma=%0d mwd=%h exp all 0",
                     u_req.resp_valid, u_req.resp_rdata, u_req.resp_err, u_mem.mem_rd,
                     u_mem.mem_wr, u_mem.mem_addr, u_mem.mem_wdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (u_req.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", u_req.req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_roundtrip;
        logic [31:0] rd, erd; logic er, srd, swr, rok, dn, eer, erdx, ewr; int lt, elt;
        ref_apply(1'b1, SZ_WORD, 1'b0, 5'd8, 32'hDEADBEEF, erd, eer, elt, erdx, ewr);
        do_op(1'b1, SZ_WORD, 1'b0, 5'd8, 32'hDEADBEEF, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if ({dn, er, srd, swr} !== 4'b1001 || lt != 2) begin
            failures++;
            $display("FAIL sw_word got done=%0b err=%0b rd=%0b wr=%0b lat=%0d exp 1 0 0 1 lat=2",
                     dn, er, srd, swr, lt);
        end
        checks++;
        if ({mem_bytes[8], mem_bytes[9], mem_bytes[10], mem_bytes[11]} !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_word_mem got=%h exp=deadbeef",
                     {mem_bytes[8], mem_bytes[9], mem_bytes[10], mem_bytes[11]});
        end
        ref_apply(1'b0, SZ_WORD, 1'b0, 5'd8, 32'h0, erd, eer, elt, erdx, ewr);
        do_op(1'b0, SZ_WORD, 1'b0, 5'd8, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lt != 2 || !dn) begin
            failures++;
            $display("FAIL lw_word got data=%h err=%0b lat=%0d exp data=deadbeef err=0 lat=2", rd, er, lt);
        end
    endtask

    task automatic test_byte_rmw;
        logic [31:0] rd, erd; logic er, srd, swr, rok, dn, eer, erdx, ewr; int lt, elt;
        ref_apply(1'b1, SZ_WORD, 1'b0, 5'd4, 32'h11223344, erd, eer, elt, erdx, ewr);
        do_op(1'b1, SZ_WORD, 1'b0, 5'd4, 32'h11223344, rd, er, lt, srd, swr, rok, dn);
        ref_apply(1'b1, SZ_BYTE, 1'b0, 5'd6, 32'h000000AA, erd, eer, elt, erdx, ewr);
        do_op(1'b1, SZ_BYTE, 1'b0, 5'd6, 32'h000000AA, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if ({dn, srd, swr, rok} !== 4'b1111 || lt != 3) begin
            failures++;
            $display("FAIL sb_rmw got done=%0b rd=%0b wr=%0b rdy_low=%0b lat=%0d exp 1 1 1 1 lat=3",
                     dn, srd, swr, rok, lt);
        end
        checks++;
        if ({mem_bytes[4], mem_bytes[5], mem_bytes[6], mem_bytes[7]} !== 32'h1122AA44) begin
            failures++;
            $display("FAIL sb_rmw_mem got=%h exp=1122aa44",
                     {mem_bytes[4], mem_bytes[5], mem_bytes[6], mem_bytes[7]});
        end
        do_op(1'b0, SZ_BYTE, 1'b1, 5'd6, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if (rd !== 32'hFFFFFFAA || lt != 2) begin
            failures++;
            $display("FAIL lb_signed got=%h lat=%0d exp=ffffffaa lat=2", rd, lt);
        end
        do_op(1'b0, SZ_BYTE, 1'b0, 5'd6, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if (rd !== 32'h000000AA) begin
            failures++;
            $display("FAIL lbu got=%h exp=000000aa", rd);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd, erd; logic er, srd, swr, rok, dn, eer, erdx, ewr; int lt, elt;
        ref_apply(1'b1, SZ_HALF, 1'b0, 5'd2, 32'h00008001, erd, eer, elt, erdx, ewr);
        do_op(1'b1, SZ_HALF, 1'b0, 5'd2, 32'h00008001, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if ({mem_bytes[0], mem_bytes[1], mem_bytes[2], mem_bytes[3]} !== 32'h00008001 || lt != 3) begin
            failures++;
            $display("FAIL sh_mem got=%h lat=%0d exp=00008001 lat=3",
                     {mem_bytes[0], mem_bytes[1], mem_bytes[2], mem_bytes[3]}, lt);
        end
        do_op(1'b0, SZ_HALF, 1'b1, 5'd2, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL lh got=%h exp=ffff8001", rd);
        end
        do_op(1'b0, SZ_HALF, 1'b0, 5'd0, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if (rd !== 32'h00000000 || er !== 1'b0) begin
            failures++;
            $display("FAIL lhu0 got=%h err=%0b exp=00000000 err=0", rd, er);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er, srd, swr, rok, dn; int lt;
        logic [7:0] snap [32];
        int diffs;
        snap = mem_bytes;
        do_op(1'b0, SZ_WORD, 1'b0, 5'd5, 32'h0, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if ({dn, er, srd, swr} !== 4'b1100 || lt != 1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL lw_mis got done=%0b err=%0b rd=%0b wr=%0b lat=%0d data=%h exp 1 1 0 0 lat=1 data=0",
                     dn, er, srd, swr, lt, rd);
        end
        do_op(1'b1, SZ_HALF, 1'b0, 5'd3, 32'h0000BEEF, rd, er, lt, srd, swr, rok, dn);
        checks++;
        if ({dn, er, srd, swr} !== 4'b1100 || lt != 1) begin
            failures++;
            $display("FAIL sh_mis got done=%0b err=%0b rd=%0b wr=%0b lat=%0d exp 1 1 0 0 lat=1",
                     dn, er, srd, swr, lt);
        end
        diffs = 0;
        for (int i = 0; i < 32; i++) if (mem_bytes[i] !== snap[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            failures++;
            $display("FAIL mis_mem_unchanged got=%0d changed bytes exp=0", diffs);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] erd; logic eer, erdx, ewr; int elt;
        int last, acc_n, gap_bad, resp_n;
        // Held load: IDLE,RD,RESP -> one accept every 3 cycles.
        u_req.req_we = 1'b0; u_req.req_size = SZ_WORD; u_req.req_signed = 1'b0;
        u_req.req_addr = 5'd8; u_req.req_wdata = 32'h0;
        u_req.req_valid = 1'b1;
        last = -1; acc_n = 0; gap_bad = 0; resp_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (u_req.resp_valid) resp_n++;
            if (u_req.req_ready) begin
                if (last >= 0 && c - last != 3) gap_bad++;
                last = c;
                acc_n++;
            end
            @(posedge clk);
            #1;
        end
        u_req.req_valid = 1'b0;
        checks++;
        if (acc_n != 4 || gap_bad != 0 || resp_n != 4) begin
            failures++;
            $display("FAIL b2b_load got accepts=%0d badgaps=%0d resps=%0d exp 4 0 4", acc_n, gap_bad, resp_n);
        end
        // Held sub-word store: IDLE,RD,WR,RESP -> one accept every 4 cycles.
        ref_apply(1'b1, SZ_BYTE, 1'b0, 5'd13, 32'h0000005A, erd, eer, elt, erdx, ewr);
        u_req.req_we = 1'b1; u_req.req_size = SZ_BYTE; u_req.req_addr = 5'd13;
        u_req.req_wdata = 32'h0000005A;
        u_req.req_valid = 1'b1;
        last = -1; acc_n = 0; gap_bad = 0; resp_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (u_req.resp_valid) resp_n++;
            if (u_req.req_ready) begin
                if (last >= 0 && c - last != 4) gap_bad++;
                last = c;
                acc_n++;
            end
            @(posedge clk);
            #1;
        end
        u_req.req_valid = 1'b0;
        checks++;
        if (acc_n != 3 || gap_bad != 0 || resp_n != 3) begin
            failures++;
            $display("FAIL b2b_sb got accepts=%0d badgaps=%0d resps=%0d exp 3 0 3", acc_n, gap_bad, resp_n);
        end
    endtask

    task automatic test_reset_mid_rmw;
        logic [7:0] b0;
        int bad;
        b0 = mem_bytes[0];
        u_req.req_we = 1'b1; u_req.req_size = SZ_BYTE; u_req.req_signed = 1'b0;
        u_req.req_addr = 5'd0; u_req.req_wdata = 32'h00000055;
        u_req.req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (u_req.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstrmw_ready got=%0b exp=1", u_req.req_ready);
        end
        @(posedge clk);
        #1 u_req.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (u_mem.mem_wr !== 1'b0 || u_req.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstrmw_wr got mem_wr=%0b resp_valid=%0b exp 0 0", u_mem.mem_wr, u_req.resp_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_req.resp_valid, u_req.resp_rdata, u_req.resp_err, u_mem.mem_rd, u_mem.mem_wr,
             u_mem.mem_addr, u_mem.mem_wdata} !== 72'h0 || u_req.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstrmw_idle got rv=%0b mrd=%0b mwr=%0b ma=%0d mwd=%h rdy=%0b exp all 0, rdy=1",
                     u_req.resp_valid, u_mem.mem_rd, u_mem.mem_wr, u_mem.mem_addr,
                     u_mem.mem_wdata, u_req.req_ready);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_req.resp_valid || u_mem.mem_wr) bad++;
        end
        checks++;
        if (bad != 0 || mem_bytes[0] !== b0) begin
            failures++;
            $display("FAIL rstrmw_quiet got stray=%0d byte0=%h exp 0 byte0=%h", bad, mem_bytes[0], b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, wd; logic er, srd, swr, rok, dn, eer, erdx, ewr; int lt, elt;
        logic we, sgn; logic [1:0] sz; logic [4:0] ad;
        int diffs;
        for (int k = 0; k < 60; k++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            ad  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ref_apply(we, sz, sgn, ad, wd, erd, eer, elt, erdx, ewr);
            do_op(we, sz, sgn, ad, wd, rd, er, lt, srd, swr, rok, dn);
            checks++;
            if (!dn || rd !== erd || er !== eer || lt != elt || srd !== erdx || swr !== ewr || !rok) begin
                failures++;
                $display("FAIL rand_%0d we=%0b sz=%0d s=%0b a=%0d got done=%0b data=%h err=%0b lat=%0d rd=%0b wr=%0b rdylow=%0b exp data=%h err=%0b lat=%0d rd=%0b wr=%0b",
                         k, we, sz, sgn, ad, dn, rd, er, lt, srd, swr, rok, erd, eer, elt, erdx, ewr);
            end
        end
        diffs = 0;
        for (int i = 0; i < 32; i++) if (mem_bytes[i] !== ref_mem[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            failures++;
            $display("FAIL final_mem got=%0d differing bytes exp=0", diffs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_req.req_valid  = 1'b0;
        u_req.req_we     = 1'b0;
        u_req.req_size   = 2'b00;
        u_req.req_signed = 1'b0;
        u_req.req_addr   = 5'd0;
        u_req.req_wdata  = 32'h0;
        test_reset();
        test_word_roundtrip();
        test_byte_rmw();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
